// File: rtl/mem_responder.sv
// Word-addressed RAM acting as the target of the mem_req / mem_wr / mem_rd channels.
// Serves one read or write burst at a time and exposes a backdoor port for preload and inspection.
module mem_responder #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_LSB      = 3,
    parameter int DEPTH_BITS    = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    output logic                     mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    input  logic                     mem_rd_ready,
    input  logic                     bd_we,
    input  logic [DEPTH_BITS-1:0]    bd_addr,
    input  logic [MEM_DATA_BITS-1:0] bd_wdata,
    output logic [MEM_DATA_BITS-1:0] bd_rdata,
    output logic                     busy,
    output logic                     err
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                   state, state_next;
    logic [DEPTH_BITS-1:0]    widx, widx_next;
    logic [MEM_LEN_BITS-1:0]  rem, rem_next;
    logic [MEM_DATA_BITS-1:0] ram [0:(1<<DEPTH_BITS)-1];
    logic [MEM_DATA_BITS-1:0] rd_bits_q;
    logic                     rd_load;
    logic [DEPTH_BITS-1:0]    rd_load_idx;
    logic                     ram_we;
    logic [DEPTH_BITS-1:0]    ram_waddr;
    logic [MEM_DATA_BITS-1:0] ram_wdata;
    logic                     violation;
    logic [DEPTH_BITS-1:0]    req_widx;
    logic                     unused_addr_bits;

    // Address bits outside the RAM's word range are deliberately ignored.
    assign req_widx         = mem_req_addr[ADDR_LSB +: DEPTH_BITS];
    assign unused_addr_bits = ^{mem_req_addr[MEM_ADDR_BITS-1:ADDR_LSB+DEPTH_BITS],
                                mem_req_addr[ADDR_LSB-1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            widx  <= '0;
            rem   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            widx  <= widx_next;
            rem   <= rem_next;
            if (violation)
                err <= 1'b1;
        end
    end

    // The backdoor write and the burst write share one RAM port; they can never collide
    // because the backdoor only writes in IDLE and bursts only write in WRITE.
    always_comb begin
        state_next  = state;
        widx_next   = widx;
        rem_next    = rem;
        rd_load     = 1'b0;
        rd_load_idx = widx;
        ram_we      = 1'b0;
        ram_waddr   = widx;
        ram_wdata   = mem_wr_bits;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    widx_next = req_widx;
                    rem_next  = mem_req_len;
                    if (!mem_req_opcode) begin
                        state_next  = READ;
                        rd_load     = 1'b1;
                        rd_load_idx = req_widx;
                    end else begin
                        state_next = WRITE;
                    end
                end
                if (bd_we) begin
                    ram_we    = 1'b1;
                    ram_waddr = bd_addr;
                    ram_wdata = bd_wdata;
                end
            end
            READ: begin
                if (mem_rd_ready) begin
                    if (rem == '0) begin
                        state_next = IDLE;
                    end else begin
                        widx_next   = widx + 1'b1;
                        rem_next    = rem - 1'b1;
                        rd_load     = 1'b1;
                        rd_load_idx = widx + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_wr_valid) begin
                    ram_we = 1'b1;
                    if (rem == '0) begin
                        state_next = IDLE;
                    end else begin
                        widx_next = widx + 1'b1;
                        rem_next  = rem - 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign violation = (mem_req_valid && (state != IDLE))
                     || (mem_wr_valid && (state != WRITE))
                     || (bd_we && (state != IDLE));

    always_ff @(posedge clock) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

    // Read data is registered so the beat stays stable while the consumer stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_bits_q <= '0;
            bd_rdata  <= '0;
        end else begin
            if (rd_load)
                rd_bits_q <= ram[rd_load_idx];
            bd_rdata <= ram[bd_addr];
        end
    end

    assign mem_rd_valid = (state == READ);
    assign mem_rd_bits  = rd_bits_q;
    assign busy         = (state != IDLE);

endmodule
